// File: rtl/pipe_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_seq_pkg: shared types, defaults and helpers for the sequencer   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pipe_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  localparam int C_DEFAULT_STAGES  = 5;
  localparam int C_DEFAULT_COUNT_W = 16;

  // Holds at all-ones of the given width; width must be below 64.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] max_v;
    max_v = (64'd1 << width) - 64'd1;
    return (value >= max_v) ? value : value + 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ready_chain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_ready_chain: per-stage valid/eof shift register and ready chain |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_ready_chain #(
  parameter int STAGES = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              load_valid,
  input  logic              load_tag,
  input  logic              out_ready,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_valid,
  output logic              out_tag
);

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_tag;
  logic [STAGES-1:0] w_rdy;

  // A stage may load when its contents will move on or it is empty, so
  // bubbles collapse even while the output is stalled.
  assign w_rdy[STAGES-1] = out_ready | ~r_valid[STAGES-1];

  generate
    for (genvar i = 0; i < STAGES - 1; i++) begin : g_rdy
      assign w_rdy[i] = w_rdy[i+1] | ~r_valid[i];
    end
  endgenerate

  assign stage_en    = w_rdy & {STAGES{~flush}};
  assign stage_valid = r_valid;
  assign out_tag     = r_tag[STAGES-1];

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      r_valid <= '0;
      r_tag   <= '0;
    end else begin
      if (stage_en[0]) begin
        r_valid[0] <= load_valid;
        r_tag[0]   <= load_tag;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (stage_en[i]) begin
          r_valid[i] <= r_valid[i-1];
          r_tag[i]   <= r_tag[i-1];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_pipe_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pixel_pipe_sequencer: stage enables, frame FSM and beat/drop counts  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pixel_pipe_sequencer
  import pipe_seq_pkg::*;
#(
  parameter int STAGES  = C_DEFAULT_STAGES,
  parameter int COUNT_W = C_DEFAULT_COUNT_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sof,
  input  logic               in_eof,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_eof,
  input  logic               flush,
  output logic [STAGES-1:0]  stage_en,
  output logic [STAGES-1:0]  stage_valid,
  output logic               busy,
  output logic               frame_done,
  output logic [COUNT_W-1:0] beat_count,
  output logic [COUNT_W-1:0] drop_count
);

  seq_state_t         r_state;
  seq_state_t         w_state_next;
  logic               w_accept;
  logic               w_load;
  logic               w_out_fire;
  logic               w_frame_end;
  logic               w_out_tag;
  logic               r_frame_done;
  logic [COUNT_W-1:0] r_beat_count;
  logic [COUNT_W-1:0] r_drop_count;

  assign in_ready   = stage_en[0] & (r_state != DRAIN);
  assign w_accept   = in_valid & in_ready;
  // Beats outside a frame are consumed but never enter the pipeline.
  assign w_load     = w_accept & ((r_state != IDLE) | in_sof);

  pipe_ready_chain #(
    .STAGES(STAGES)
  ) u_chain (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .load_valid  (w_load),
    .load_tag    (w_load & in_eof),
    .out_ready   (out_ready),
    .stage_en    (stage_en),
    .stage_valid (stage_valid),
    .out_tag     (w_out_tag)
  );

  assign out_valid   = stage_valid[STAGES-1];
  assign out_eof     = w_out_tag & out_valid;
  assign w_out_fire  = out_valid & out_ready & ~flush;
  assign w_frame_end = w_out_fire & out_eof & (r_state == DRAIN);
  assign busy        = (|stage_valid) | (r_state != IDLE);
  assign frame_done  = r_frame_done;
  assign beat_count  = r_beat_count;
  assign drop_count  = r_drop_count;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && in_sof) w_state_next = in_eof ? DRAIN : RUN;
      RUN:     if (w_accept && in_eof) w_state_next = DRAIN;
      DRAIN:   if (w_frame_end)        w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // frame_done is registered so the final count stays visible for the
  // pulse cycle; the count is cleared on the edge that ends the pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_frame_done <= 1'b0;
      r_beat_count <= '0;
      r_drop_count <= '0;
    end else begin
      r_frame_done <= w_frame_end;
      if (flush || r_frame_done) begin
        r_beat_count <= '0;
      end else if (w_out_fire) begin
        r_beat_count <= COUNT_W'(sat_inc(64'(r_beat_count), COUNT_W));
      end
      if (w_accept && (r_state == IDLE) && !in_sof) begin
        r_drop_count <= COUNT_W'(sat_inc(64'(r_drop_count), COUNT_W));
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_pipe_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pixel_pipe_sequencer: vector table, scoreboard and corner cases   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pixel_pipe_sequencer;

  localparam int STAGES  = 5;
  localparam int COUNT_W = 16;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_sof = 1'b0;
  logic               in_eof = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               out_eof;
  logic               flush = 1'b0;
  logic [STAGES-1:0]  stage_en;
  logic [STAGES-1:0]  stage_valid;
  logic               busy;
  logic               frame_done;
  logic [COUNT_W-1:0] beat_count;
  logic [COUNT_W-1:0] drop_count;

  int tests = 0;
  int fails = 0;

  pixel_pipe_sequencer #(
    .STAGES (STAGES),
    .COUNT_W(COUNT_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_eof     (in_eof),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_eof    (out_eof),
    .flush      (flush),
    .stage_en   (stage_en),
    .stage_valid(stage_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .beat_count (beat_count),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: eof tag of every loaded beat, in order; reference frame state.
  logic sb[$];
  int   m_state = 0;  // 0 idle, 1 run, 2 drain

  always @(negedge clock) begin
    logic exp_eof;
    if (!reset_n || flush) begin
      sb.delete();
      m_state = 0;
    end else begin
      if (m_state == 2) check("drain_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_beat", 32'(out_valid), 32'd0);
        end else begin
          exp_eof = sb.pop_front();
          check("sb_out_eof", 32'(out_eof), 32'(exp_eof));
          if (exp_eof && m_state == 2) m_state = 0;
        end
      end
      if (in_valid && in_ready) begin
        if (m_state != 0 || in_sof) begin
          sb.push_back(in_eof);
          m_state = in_eof ? 2 : 1;
        end
      end
    end
  end

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_eof    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_in_ready",  32'(in_ready),    32'd1);
    check("rst_out_valid", 32'(out_valid),   32'd0);
    check("rst_busy",      32'(busy),        32'd0);
    check("rst_sv",        32'(stage_valid), 32'd0);
    check("rst_counts",    {beat_count, drop_count}, 32'd0);
    tick();
  endtask

  task automatic send_beat(input logic sof, input logic eof);
    logic got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_eof   = eof;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    check("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_done(input int exp_count);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (frame_done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("frame_done_timeout", 32'(got), 32'd1);
    check("count_at_done", 32'(beat_count), 32'(exp_count));
    tick();
  endtask

  typedef struct {
    logic       iv, sof, eof, ordy;
    logic       e_irdy, e_ov, e_oeof, e_busy, e_fd;
    logic [4:0] e_sv;
    int         e_bc;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 4-beat frame, no stall: cycle-by-cycle expectations from first accept.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00001, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00011, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00111, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b01111, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11110, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11100, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11000, 2};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b10000, 3};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 4};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 0};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      in_valid  = tbl[i].iv;
      in_sof    = tbl[i].sof;
      in_eof    = tbl[i].eof;
      out_ready = tbl[i].ordy;
      @(negedge clock);
      check($sformatf("t1_in_ready[%0d]", i),  32'(in_ready),    32'(tbl[i].e_irdy));
      check($sformatf("t1_out_valid[%0d]", i), 32'(out_valid),   32'(tbl[i].e_ov));
      check($sformatf("t1_out_eof[%0d]", i),   32'(out_eof),     32'(tbl[i].e_oeof));
      check($sformatf("t1_busy[%0d]", i),      32'(busy),        32'(tbl[i].e_busy));
      check($sformatf("t1_done[%0d]", i),      32'(frame_done),  32'(tbl[i].e_fd));
      check($sformatf("t1_sv[%0d]", i),        32'(stage_valid), 32'(tbl[i].e_sv));
      check($sformatf("t1_bc[%0d]", i),        32'(beat_count),  32'(tbl[i].e_bc));
      tick();
    end
    in_valid = 1'b0;

    // Stalled output with a mid-frame bubble, then release.
    do_reset();
    out_ready = 1'b0;
    send_beat(1'b1, 1'b0);
    send_beat(1'b0, 1'b0);
    tick();
    send_beat(1'b0, 1'b0);
    send_beat(1'b0, 1'b0);
    send_beat(1'b0, 1'b0);
    in_valid = 1'b1;
    in_eof   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("stall_sv",        32'(stage_valid), 32'h1f);
      check("stall_in_ready",  32'(in_ready),    32'd0);
      check("stall_out_valid", 32'(out_valid),   32'd1);
      check("stall_last_en",   32'(stage_en[STAGES-1]), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    send_beat(1'b0, 1'b1);
    wait_done(6);
    check("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Beats outside a frame are dropped.
    do_reset();
    send_beat(1'b0, 1'b0);
    send_beat(1'b0, 1'b0);
    send_beat(1'b0, 1'b0);
    check("drop_count", 32'(drop_count), 32'd3);
    send_beat(1'b1, 1'b0);
    send_beat(1'b0, 1'b1);
    wait_done(2);

    // Flush with beats in flight and input pending.
    do_reset();
    send_beat(1'b0, 1'b0);
    send_beat(1'b1, 1'b0);
    for (int k = 0; k < 6; k++) send_beat(1'b0, 1'b0);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clock);
    check("flush_pre_bc",   32'(beat_count), 32'd2);
    check("flush_in_ready", 32'(in_ready),   32'd0);
    check("flush_stage_en", 32'(stage_en),   32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    check("flush_sv",    32'(stage_valid), 32'd0);
    check("flush_busy",  32'(busy),        32'd0);
    check("flush_done",  32'(frame_done),  32'd0);
    check("flush_bc",    32'(beat_count),  32'd0);
    check("flush_drop",  32'(drop_count),  32'd1);
    tick();

    // Single-beat frame goes straight to drain.
    do_reset();
    send_beat(1'b1, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      check($sformatf("single_done[%0d]", k), 32'(frame_done), 32'(k == 6));
      check($sformatf("single_in_ready[%0d]", k), 32'(in_ready), 32'(k == 6));
      if (k == 6) check("single_bc", 32'(beat_count), 32'd1);
      tick();
    end

    // Reset in the middle of a drain.
    do_reset();
    send_beat(1'b0, 1'b0);
    send_beat(1'b1, 1'b1);
    tick();
    @(negedge clock);
    check("mid_drain_busy", 32'(busy), 32'd1);
    check("mid_drain_drop", 32'(drop_count), 32'd1);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clock);
    check("mrst_out_valid", 32'(out_valid),   32'd0);
    check("mrst_busy",      32'(busy),        32'd0);
    check("mrst_in_ready",  32'(in_ready),    32'd1);
    check("mrst_sv",        32'(stage_valid), 32'd0);
    check("mrst_done",      32'(frame_done),  32'd0);
    check("mrst_counts",    {beat_count, drop_count}, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
